// File: rtl/fsmd_operand_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fsmd_operand_sequencer
// Description : Command FIFO plus issue sequencer for the FSMD adder/subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
module fsmd_operand_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [1:0] cmd_op_i,
  input  logic [7:0] cmd_a_i,
  input  logic [7:0] cmd_b_i,
  output logic [1:0] operation_o,
  output logic [7:0] a_o,
  output logic [7:0] b_o,
  input  logic [8:0] result_i,
  output logic       res_valid_o,
  output logic [8:0] res_data_o,
  output logic       busy_o,
  output logic [7:0] drop_count_o
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] SEQ_IDLE  = 3'd0;
  localparam logic [2:0] SEQ_ISSUE = 3'd1;
  localparam logic [2:0] SEQ_CALC  = 3'd2;
  localparam logic [2:0] SEQ_WAIT  = 3'd3;
  localparam logic [2:0] SEQ_RESP  = 3'd4;

  localparam logic [1:0] OP_NONE = 2'b11;

  logic [17:0] mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        full_w, empty_w, accept_w, push_w, pop_w;
  logic [17:0] head_w;

  logic [2:0]  state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [7:0]  a_q, a_d, b_q, b_d;
  logic        res_valid_q, res_valid_d;
  logic [8:0]  res_data_q, res_data_d;
  logic [7:0]  drop_q;

  // Extra pointer bit distinguishes full from empty when the low bits match.
  assign full_w   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_w  = (wr_ptr_q == rd_ptr_q);
  assign accept_w = cmd_valid_i && !full_w;
  assign push_w   = accept_w && !cmd_op_i[1];
  assign head_w   = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (push_w) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {cmd_op_i, cmd_a_i, cmd_b_i};
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      drop_q   <= 8'd0;
    end else begin
      if (push_w) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_w)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (accept_w && cmd_op_i[1] && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    res_valid_d = 1'b0;
    res_data_d  = res_data_q;
    pop_w       = 1'b0;
    case (state_q)
      SEQ_IDLE: begin
        op_d = OP_NONE;
        if (!empty_w) begin
          pop_w   = 1'b1;
          op_d    = head_w[17:16];
          a_d     = head_w[15:8];
          b_d     = head_w[7:0];
          state_d = SEQ_ISSUE;
        end
      end
      SEQ_ISSUE: state_d = SEQ_CALC;
      SEQ_CALC: begin
        // Dropping the op here keeps downstream from re-entering CALCULATE.
        op_d    = OP_NONE;
        state_d = SEQ_WAIT;
      end
      SEQ_WAIT: state_d = SEQ_RESP;
      SEQ_RESP: begin
        res_data_d  = result_i;
        res_valid_d = 1'b1;
        if (!empty_w) begin
          pop_w   = 1'b1;
          op_d    = head_w[17:16];
          a_d     = head_w[15:8];
          b_d     = head_w[7:0];
          state_d = SEQ_ISSUE;
        end else begin
          state_d = SEQ_IDLE;
        end
      end
      default: begin
        op_d    = OP_NONE;
        state_d = SEQ_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= SEQ_IDLE;
      op_q        <= OP_NONE;
      a_q         <= 8'd0;
      b_q         <= 8'd0;
      res_valid_q <= 1'b0;
      res_data_q  <= 9'd0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  assign cmd_ready_o  = !full_w;
  assign operation_o  = op_q;
  assign a_o          = a_q;
  assign b_o          = b_q;
  assign res_valid_o  = res_valid_q;
  assign res_data_o   = res_data_q;
  assign busy_o       = (state_q != SEQ_IDLE) || !empty_w;
  assign drop_count_o = drop_q;

endmodule
`default_nettype wire
